lh_msg_feeder: RTL
==================

# lh_msg_feeder

Initiator-side sequencer for the `light_hash` core. Accepts a message as a valid/ready byte stream with a last flag and drives the core's command protocol: head, one message command per byte, tail. After tail it waits for `digest_ready`, captures the 64-bit digest with the byte count, and holds both on a valid/ready output port. It sits between any byte source (UART, FIFO, bus bridge) and one `light_hash` instance.

## Interface
- `TIMEOUT_CYCLES`, 1024: watchdog limit, used only with the timeout feature compiled in.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: feeder accepts a byte this cycle.
- `in_byte` in 8: message byte.
- `in_last` in 1: this byte is the last of the message.
- `in_empty` in 1: with `in_last`, marks a zero-length message; `in_byte` is ignored.
- `lh_message_valid` out 1: one-cycle command strobe to the core.
- `lh_state` out 2: command to the core: head=2'b00, tail=2'b01, message=2'b10, idle=2'b11.
- `lh_message_byte` out 8: byte for the message command.
- `lh_next_byte` in 1: core busy flag. While high, no new command may be issued.
- `lh_digest` in 64: core digest.
- `lh_digest_ready` in 1: core digest valid.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_digest` out 64: captured digest.
- `out_len` out 16: number of message bytes sent. Saturates at 16'hFFFF.
- `out_error` out 1: watchdog abort flag. Constant 0 without the macro.

## Operation
- FSM states: IDLE, CMD, GAP, BUSY, FETCH, DIGEST, OUT, plus DRAIN (macro only). A `cmd` register (HEAD/MSG/TAIL) selects what CMD issues.
- IDLE:
  - `lh_state`=2'b11.
  - When `in_valid`=1, set cmd=HEAD and go to CMD. The byte is not consumed.
  - Clear the length counter.
- CMD:
  - Assert `lh_message_valid`=1 for exactly one cycle.
  - `lh_state` carries the command encoding. For MSG, `lh_message_byte` carries the latched byte.
  - Go to GAP.
- GAP: one cycle with `lh_message_valid`=0. Then go to DIGEST if cmd=TAIL, otherwise BUSY.
- BUSY: wait for `lh_next_byte`=0, then:
  - cmd=HEAD: go to FETCH.
  - cmd=MSG, last flag clear: go to FETCH.
  - cmd=MSG, last flag set: set cmd=TAIL and go to CMD.
- FETCH:
  - `in_ready`=1 (combinational, decoded from the state only).
  - On `in_valid`, `in_empty`=0: latch the byte and `in_last`, increment `out_len` (saturating), set cmd=MSG, go to CMD.
  - On `in_valid`, `in_last`=1, `in_empty`=1: consume, set cmd=TAIL, go to CMD.
  - `in_empty` without `in_last` is treated as a normal byte.
- DIGEST: on `lh_digest_ready`=1, register `lh_digest` into `out_digest` and go to OUT.
- OUT: `out_valid`=1. On `out_ready`, go to IDLE.
- `lh_state` and `lh_message_byte` are registered and hold their values between strobes. `lh_state` returns to 2'b11 on entry to IDLE.
- `out_digest` and `out_len` hold until the next capture.
- Ignored inputs: `lh_digest_ready` outside DIGEST; `lh_next_byte` outside BUSY; `in_valid` outside IDLE/FETCH.
- The feeder never drives the core reset. After `rst`, the system must also reset the core.

## Timing
- Reset values:
  - `lh_message_valid`=0, `lh_state`=2'b11, `lh_message_byte`=8'h00.
  - `in_ready`=0, `out_valid`=0, `out_digest`=64'h0, `out_len`=16'h0, `out_error`=0.
  - FSM in IDLE.
- Minimum per byte: 4 cycles (FETCH, CMD, GAP, BUSY with `lh_next_byte` already low).
- Head overhead: 3 cycles minimum (CMD, GAP, BUSY).
- Tail to `out_valid`: 2 cycles plus the core digest latency. `out_valid` rises the cycle after `lh_digest_ready` is sampled high.
- `out_valid` with `out_ready` high in the same cycle: handshake completes, IDLE on the next edge. A new message can start one cycle later.
- `rst` asserted mid-message: all outputs take their reset values immediately (asynchronous). The partial message is abandoned and no result is produced.

## Configuration
- Macro `LH_FEEDER_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog counts cycles in BUSY and DIGEST and clears on every state change.
  - On reaching `TIMEOUT_CYCLES`, the feeder sets `out_error`=1 and `out_digest`=64'h0.
  - If the last byte is already consumed, go directly to OUT.
  - Otherwise go to DRAIN: `in_ready`=1, discard bytes up to and including the one with `in_last`, then go to OUT.
  - `out_error` clears on leaving OUT.
- Not defined: no counter, no DRAIN state, BUSY and DIGEST wait indefinitely, `out_error` tied to 0.

## Test plan
- "H4rdw4r3_Tr0j4n" through a real `light_hash` -> `out_digest`=64'h5aecbf4f5fe467bc, `out_len`=15. Exactly 17 strobes: 1 head, 15 message, 1 tail.
- "3.141592653589793238", with `in_valid` toggled randomly -> `out_digest`=64'hf9e317d512022e21, `out_len`=20.
- Back-to-back "AlessandroAndGiacomo" then "AlessandroandGiacomo", `out_ready` held low 10 cycles each -> 64'he19e79abcdf021f1 then 64'h48f63b14b5c40a5a. Results stable while stalled.
- Empty message (`in_last`=1, `in_empty`=1) against a core model -> head strobe, then tail strobe, `out_len`=0.
- Core model holding `lh_next_byte` high 50 cycles after byte 3 -> no strobe until 1 cycle after it falls. With the macro and `TIMEOUT_CYCLES`=32: `out_error`=1, remaining bytes drained, `out_digest`=0.
- `rst` pulsed during byte 5 of a 15-byte message -> all outputs at reset values. A following full message hashes correctly after the core is also reset.

Source files
------------

// File: rtl/lh_msg_feeder_if.sv
// lh_msg_feeder_if: byte stream in, light_hash command/digest, and result port of the feeder
interface lh_msg_feeder_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        in_last;
   logic        in_empty;
   logic        lh_message_valid;
   logic [1:0]  lh_state;
   logic [7:0]  lh_message_byte;
   logic        lh_next_byte;
   logic [63:0] lh_digest;
   logic        lh_digest_ready;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_digest;
   logic [15:0] out_len;
   logic        out_error;
   modport master (
      input  in_valid, in_byte, in_last, in_empty, lh_next_byte, lh_digest, lh_digest_ready, out_ready,
      output in_ready, lh_message_valid, lh_state, lh_message_byte, out_valid, out_digest, out_len, out_error
   );
   modport slave (
      output in_valid, in_byte, in_last, in_empty, lh_next_byte, lh_digest, lh_digest_ready, out_ready,
      input  in_ready, lh_message_valid, lh_state, lh_message_byte, out_valid, out_digest, out_len, out_error
   );
endinterface

// File: rtl/lh_msg_feeder.sv
// lh_msg_feeder: drives light_hash head/message/tail commands from a byte stream and returns the digest.
// Define LH_FEEDER_TIMEOUT_EN to add a watchdog that aborts stalled BUSY/DIGEST waits.
module lh_msg_feeder #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic            clk,
   input logic            rst,
   lh_msg_feeder_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, CMD, GAP, BUSY, FETCH, DIGEST, OUT
`ifdef LH_FEEDER_TIMEOUT_EN
      , DRAIN
`endif
   } state_t;
   // command codes double as the lh_state encoding
   typedef enum logic [1:0] {HEAD = 2'b00, TAIL = 2'b01, MSG = 2'b10} cmd_t;
   state_t      state_q;
   cmd_t        cmd_q;
   logic        last_q;
   logic        valid_q;
   logic [1:0]  lh_state_q;
   logic [7:0]  byte_q;
   logic [15:0] len_q;
   logic [15:0] out_len_q;
   logic [63:0] digest_q;
`ifdef LH_FEEDER_TIMEOUT_EN
   logic [15:0] wd_q;
   logic        error_q;
   logic        wd_hit;
   assign wd_hit       = wd_q == 16'(TIMEOUT_CYCLES - 1);
   assign bus.in_ready  = state_q == FETCH || state_q == DRAIN;
   assign bus.out_error = error_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign bus.in_ready  = state_q == FETCH;
   assign bus.out_error = 1'b0;
`endif
   assign bus.lh_message_valid = valid_q;
   assign bus.lh_state         = lh_state_q;
   assign bus.lh_message_byte  = byte_q;
   assign bus.out_valid        = state_q == OUT;
   assign bus.out_digest       = digest_q;
   assign bus.out_len          = out_len_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cmd_q      <= HEAD;
         last_q     <= 1'b0;
         valid_q    <= 1'b0;
         lh_state_q <= 2'b11;
         byte_q     <= 8'h00;
         len_q      <= 16'h0;
         out_len_q  <= 16'h0;
         digest_q   <= 64'h0;
`ifdef LH_FEEDER_TIMEOUT_EN
         wd_q       <= 16'h0;
         error_q    <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
`ifdef LH_FEEDER_TIMEOUT_EN
         wd_q <= (state_q == BUSY || state_q == DIGEST) ? wd_q + 16'd1 : 16'd0;
`endif
         case (state_q)
            IDLE: begin
               len_q  <= 16'h0;
               last_q <= 1'b0;
               if (bus.in_valid) begin
                  cmd_q      <= HEAD;
                  lh_state_q <= HEAD;
                  valid_q    <= 1'b1;
                  state_q    <= CMD;
               end
            end
            CMD: state_q <= GAP;
            GAP: state_q <= cmd_q == TAIL ? DIGEST : BUSY;
            BUSY:
`ifdef LH_FEEDER_TIMEOUT_EN
               if (wd_hit) begin
                  error_q   <= 1'b1;
                  digest_q  <= 64'h0;
                  out_len_q <= len_q;
                  state_q   <= last_q ? OUT : DRAIN;
               end else
`endif
               if (!bus.lh_next_byte) begin
                  if (cmd_q == MSG && last_q) begin
                     cmd_q      <= TAIL;
                     lh_state_q <= TAIL;
                     valid_q    <= 1'b1;
                     state_q    <= CMD;
                  end else
                     state_q <= FETCH;
               end
            FETCH:
               if (bus.in_valid) begin
                  valid_q <= 1'b1;
                  state_q <= CMD;
                  if (bus.in_last && bus.in_empty) begin
                     cmd_q      <= TAIL;
                     lh_state_q <= TAIL;
                     last_q     <= 1'b1;
                  end else begin
                     cmd_q      <= MSG;
                     lh_state_q <= MSG;
                     byte_q     <= bus.in_byte;
                     last_q     <= bus.in_last;
                     len_q      <= len_q + {15'd0, ~&len_q};
                  end
               end
            DIGEST:
`ifdef LH_FEEDER_TIMEOUT_EN
               if (wd_hit) begin
                  error_q   <= 1'b1;
                  digest_q  <= 64'h0;
                  out_len_q <= len_q;
                  state_q   <= OUT;
               end else
`endif
               if (bus.lh_digest_ready) begin
                  digest_q  <= bus.lh_digest;
                  out_len_q <= len_q;
                  state_q   <= OUT;
               end
            OUT:
               if (bus.out_ready) begin
                  lh_state_q <= 2'b11;
                  state_q    <= IDLE;
`ifdef LH_FEEDER_TIMEOUT_EN
                  error_q    <= 1'b0;
`endif
               end
`ifdef LH_FEEDER_TIMEOUT_EN
            DRAIN: if (bus.in_valid && bus.in_last) state_q <= OUT;
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
